// File: rtl/sp_bsram_pkg.sv
// Shared widths, request record and latency helper for the SP BSRAM request controller.
package sp_bsram_pkg;

    localparam int WordAddrWidth = 9;
    localparam int BeWidth       = 4;
    localparam int SpAdWidth     = 14;
    localparam int DataWidth     = 32;

    typedef struct packed {
        logic                     we;
        logic [WordAddrWidth-1:0] addr;
        logic [BeWidth-1:0]       be;
        logic [DataWidth-1:0]     wdata;
    } sp_req_t;

    function automatic int read_latency(input logic out_reg);
        return out_reg ? 2 : 1;
    endfunction

endpackage

// File: rtl/sp_bsram_ctrl_if.sv
// Request/response valid-ready streams between the local-memory arbiter and one BSRAM controller.
interface sp_bsram_ctrl_if import sp_bsram_pkg::*; ();

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_we_i;
    logic [WordAddrWidth-1:0] req_addr_i;
    logic [BeWidth-1:0]       req_be_i;
    logic [DataWidth-1:0]     req_wdata_i;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [DataWidth-1:0]     rsp_rdata_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o
    );

endinterface

// File: rtl/sp_rsp_fifo.sv
// Registered synchronous response FIFO; head entry drives dout directly.
module sp_rsp_fifo import sp_bsram_pkg::*; #(
    parameter int Depth = 4,
    parameter int Width = DataWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic [CntW-1:0]  count;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign full   = (count == CntW'(Depth));
    assign empty  = (count == '0);
    assign dout   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= (wptr == LastPtr) ? '0 : wptr + PtrW'(1);
            end
            if (do_pop) begin
                rptr <= (rptr == LastPtr) ? '0 : rptr + PtrW'(1);
            end
            if (push && !do_pop) begin
                count <= count + CntW'(1);
            end else if (do_pop && !push) begin
                count <= count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/sp_bsram_ctrl.sv
// Request-side controller for one Gowin SP BSRAM (512 x 32): drives the port pins,
// tracks read latency and returns read data in order with credit-based flow control.
module sp_bsram_ctrl import sp_bsram_pkg::*; #(
    parameter logic       OutReg   = 1'b1,
    parameter int         RspDepth = 4,
    parameter logic [2:0] BlkSel   = 3'b000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    sp_bsram_ctrl_if.slave       bus,
    input  logic [DataWidth-1:0] sp_do_i,
    output logic [DataWidth-1:0] sp_di_o,
    output logic [SpAdWidth-1:0] sp_ad_o,
    output logic [2:0]           sp_blksel_o,
    output logic                 sp_wre_o,
    output logic                 sp_ce_o,
    output logic                 sp_oce_o,
    output logic                 sp_reset_o
);

    localparam int Lat = read_latency(OutReg);
    localparam int CrW = $clog2(RspDepth + 1);

    sp_req_t        req;
    logic [CrW-1:0] credits;
    logic [Lat-1:0] tok;
    logic           accept;
    logic           rd_accept;
    logic           rsp_hs;
    logic           fifo_push;
    logic           fifo_full;
    logic           fifo_empty;

    assign req = {bus.req_we_i, bus.req_addr_i, bus.req_be_i, bus.req_wdata_i};

    assign bus.req_ready_o = (credits != '0);
    assign accept          = bus.req_valid_i && bus.req_ready_o && !RESET;
    assign rd_accept       = accept && !req.we;
    assign rsp_hs          = bus.rsp_valid_o && bus.rsp_ready_i;

    // Reads carry all-ones byte lanes so the full word is presented on DO.
    assign sp_ce_o     = accept;
    assign sp_wre_o    = accept && req.we;
    assign sp_ad_o     = {req.addr, 1'b0, (req.we ? req.be : 4'hF)};
    assign sp_di_o     = req.wdata;
    assign sp_blksel_o = BlkSel;
    assign sp_reset_o  = RESET;
    assign sp_oce_o    = OutReg ? tok[0] : 1'b1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            credits <= CrW'(RspDepth);
        end else if (rd_accept && !rsp_hs) begin
            credits <= credits - CrW'(1);
        end else if (rsp_hs && !rd_accept) begin
            credits <= credits + CrW'(1);
        end
    end

    generate
        if (Lat == 1) begin : g_pipe_l1
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    tok <= '0;
                end else begin
                    tok <= rd_accept;
                end
            end
        end else begin : g_pipe_ln
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    tok <= '0;
                end else begin
                    tok <= {tok[Lat-2:0], rd_accept};
                end
            end
        end
    endgenerate

    assign fifo_push       = tok[Lat-1];
    assign bus.rsp_valid_o = !fifo_empty;

    sp_rsp_fifo #(
        .Depth (RspDepth),
        .Width (DataWidth)
    ) u_rsp_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (fifo_push),
        .din   (sp_do_i),
        .pop   (rsp_hs),
        .dout  (bus.rsp_rdata_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Credits bound outstanding reads to the FIFO depth, so a full-FIFO push is a design bug.
    assert property (@(posedge CLK) disable iff (RESET) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_sp_bsram_ctrl.sv
// Directed bench for sp_bsram_ctrl: one instance with the output register, one without,
// each driving a behavioural SP BSRAM model.
module tb_sp_bsram_ctrl;
    import sp_bsram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sp_bsram_ctrl_if bus_a ();
    sp_bsram_ctrl_if bus_b ();

    logic [31:0] do_a, di_a, do_b, di_b;
    logic [13:0] ad_a, ad_b;
    logic [2:0]  blksel_a, blksel_b;
    logic        wre_a, ce_a, oce_a, reset_a;
    logic        wre_b, ce_b, oce_b, reset_b;

    sp_bsram_ctrl #(.OutReg(1'b1), .RspDepth(4), .BlkSel(3'b000)) u_dut_a (
        .CLK(clk), .RESET(rst), .bus(bus_a),
        .sp_do_i(do_a), .sp_di_o(di_a), .sp_ad_o(ad_a), .sp_blksel_o(blksel_a),
        .sp_wre_o(wre_a), .sp_ce_o(ce_a), .sp_oce_o(oce_a), .sp_reset_o(reset_a)
    );

    sp_bsram_ctrl #(.OutReg(1'b0), .RspDepth(4), .BlkSel(3'b101)) u_dut_b (
        .CLK(clk), .RESET(rst), .bus(bus_b),
        .sp_do_i(do_b), .sp_di_o(di_b), .sp_ad_o(ad_b), .sp_blksel_o(blksel_b),
        .sp_wre_o(wre_b), .sp_ce_o(ce_b), .sp_oce_o(oce_b), .sp_reset_o(reset_b)
    );

    // Behavioural BSRAMs: normal write mode, optional OCE-gated output register.
    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];
    logic [31:0] lat_a, oreg_a, lat_b;

    always @(posedge clk) begin
        if (ce_a) begin
            if (wre_a) begin
                for (int b = 0; b < 4; b++)
                    if (ad_a[b]) mem_a[ad_a[13:5]][8*b +: 8] <= di_a[8*b +: 8];
            end else begin
                lat_a <= mem_a[ad_a[13:5]];
            end
        end
        if (oce_a) oreg_a <= lat_a;
    end
    assign do_a = oreg_a;

    always @(posedge clk) begin
        if (ce_b) begin
            if (wre_b) begin
                for (int b = 0; b < 4; b++)
                    if (ad_b[b]) mem_b[ad_b[13:5]][8*b +: 8] <= di_b[8*b +: 8];
            end else begin
                lat_b <= mem_b[ad_b[13:5]];
            end
        end
    end
    assign do_b = lat_b;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [13:0] exp_ad;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [9];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] refm [8];
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    int          k, c, n_acc, got, stale, n_ops, oce_bad;
    logic        ok;
    logic        r_we;
    logic [2:0]  r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic step_a(input logic v, input logic we, input logic [8:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        bus_a.req_valid_i = v;
        bus_a.req_we_i    = we;
        bus_a.req_addr_i  = addr;
        bus_a.req_be_i    = be;
        bus_a.req_wdata_i = wd;
        @(posedge clk);
    endtask

    task automatic step_b(input logic v, input logic we, input logic [8:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        bus_b.req_valid_i = v;
        bus_b.req_we_i    = we;
        bus_b.req_addr_i  = addr;
        bus_b.req_be_i    = be;
        bus_b.req_wdata_i = wd;
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus_a.req_valid_i = 1'b1;
        bus_a.req_we_i    = 1'b1;
        bus_a.req_addr_i  = 9'h1A5;
        bus_a.req_be_i    = 4'hF;
        bus_a.req_wdata_i = 32'h0;
        bus_a.rsp_ready_i = 1'b1;
        bus_b.req_valid_i = 1'b0;
        bus_b.req_we_i    = 1'b0;
        bus_b.req_addr_i  = 9'h0;
        bus_b.req_be_i    = 4'h0;
        bus_b.req_wdata_i = 32'h0;
        bus_b.rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus_a.req_ready_o, 1);
        chk("rst_rsp_valid", bus_a.rsp_valid_o, 0);
        chk("rst_rsp_rdata", bus_a.rsp_rdata_o, 0);
        chk("rst_ce", ce_a, 0);
        chk("rst_wre", wre_a, 0);
        chk("rst_oce_a", oce_a, 0);
        chk("rst_oce_b", oce_b, 1);
        chk("rst_sp_reset", reset_a, 1);
        chk("blksel_a", blksel_a, 3'b000);
        chk("blksel_b", blksel_b, 3'b101);
        bus_a.req_valid_i = 1'b0;
        rst = 1'b0;
        #1 chk("sp_reset_released", reset_a, 0);

        vecs[0] = '{1'b1, 9'h1A5, 4'hF,    32'hDEADBEEF, 14'h34AF, 32'h0};
        vecs[1] = '{1'b0, 9'h1A5, 4'h0,    32'h0,        14'h34AF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 9'h010, 4'hF,    32'hFFFFFFFF, 14'h020F, 32'h0};
        vecs[3] = '{1'b1, 9'h010, 4'b0101, 32'h11223344, 14'h0205, 32'h0};
        vecs[4] = '{1'b0, 9'h010, 4'h0,    32'h0,        14'h020F, 32'hFF22FF44};
        vecs[5] = '{1'b1, 9'h1FF, 4'hF,    32'h00000000, 14'h3FEF, 32'h0};
        vecs[6] = '{1'b1, 9'h1FF, 4'b1000, 32'hAABBCCDD, 14'h3FE8, 32'h0};
        vecs[7] = '{1'b0, 9'h1FF, 4'h0,    32'h0,        14'h3FEF, 32'hAA000000};
        vecs[8] = '{1'b0, 9'h010, 4'h0,    32'h0,        14'h020F, 32'hFF22FF44};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus_a.req_valid_i = 1'b1;
            bus_a.req_we_i    = vecs[i].we;
            bus_a.req_addr_i  = vecs[i].addr;
            bus_a.req_be_i    = vecs[i].be;
            bus_a.req_wdata_i = vecs[i].wdata;
            #1;
            chk("vec_ready", bus_a.req_ready_o, 1);
            chk("vec_ce", ce_a, 1);
            chk("vec_wre", wre_a, vecs[i].we);
            chk("vec_ad", ad_a, vecs[i].exp_ad);
            if (vecs[i].we) chk("vec_di", di_a, vecs[i].wdata);
            @(posedge clk);
            if (!vecs[i].we) begin
                k  = 0;
                ok = 1'b0;
                while (k < 8 && !ok) begin
                    @(negedge clk);
                    k++;
                    if (k == 1) begin
                        bus_a.req_valid_i = 1'b0;
                        chk("oce_stage1", oce_a, 1);
                    end
                    if (k == 2) chk("oce_stage2", oce_a, 0);
                    ok = bus_a.rsp_valid_o;
                end
                chk("rd_latency", k, 3);
                chk("rd_data", bus_a.rsp_rdata_o, vecs[i].exp_rdata);
            end
        end
        @(negedge clk);
        bus_a.req_valid_i = 1'b0;

        // Backpressure: six reads offered with the consumer stalled.
        for (int i = 0; i < 6; i++) step_a(1'b1, 1'b1, 9'h100 + 9'(i), 4'hF, 32'hC0DE0000 + 32'(i));
        step_a(1'b0, 1'b0, 9'h0, 4'h0, 32'h0);
        bus_a.rsp_ready_i = 1'b0;
        n_acc = 0;
        for (int cc = 0; cc < 10; cc++) begin
            @(negedge clk);
            bus_a.req_valid_i = 1'b1;
            bus_a.req_we_i    = 1'b0;
            bus_a.req_addr_i  = 9'h100 + 9'(n_acc);
            bus_a.req_be_i    = 4'h0;
            #1 ok = bus_a.req_ready_o;
            @(posedge clk);
            if (ok) n_acc++;
        end
        chk("bp_accepts", n_acc, 4);
        @(negedge clk);
        #1;
        chk("bp_ready_low", bus_a.req_ready_o, 0);
        chk("bp_head", bus_a.rsp_rdata_o, 32'hC0DE0000);
        bus_a.req_we_i    = 1'b1;
        bus_a.req_addr_i  = 9'h1F0;
        bus_a.req_be_i    = 4'hF;
        bus_a.req_wdata_i = 32'h55;
        #1;
        chk("zc_wr_ready", bus_a.req_ready_o, 0);
        chk("zc_wr_ce", ce_a, 0);
        @(posedge clk);
        @(negedge clk);
        bus_a.req_valid_i = 1'b0;
        bus_a.rsp_ready_i = 1'b1;
        #1 chk("rel_ready_same_cycle", bus_a.req_ready_o, 0);
        @(posedge clk);
        @(negedge clk);
        bus_a.rsp_ready_i = 1'b0;
        #1 chk("recover_ready", bus_a.req_ready_o, 1);
        got = 1;
        c   = 0;
        while (got < 6 && c < 40) begin
            @(negedge clk);
            c++;
            bus_a.rsp_ready_i = 1'b1;
            bus_a.req_we_i    = 1'b0;
            bus_a.req_valid_i = (n_acc < 6);
            bus_a.req_addr_i  = 9'h100 + 9'(n_acc);
            #1 ok = bus_a.req_valid_i && bus_a.req_ready_o;
            if (bus_a.rsp_valid_o) begin
                chk("bp_order", bus_a.rsp_rdata_o, 32'hC0DE0000 + 32'(got));
                got++;
            end
            @(posedge clk);
            if (ok) n_acc++;
        end
        chk("bp_total", got, 6);
        step_a(1'b0, 1'b0, 9'h0, 4'h0, 32'h0);
        step_a(1'b0, 1'b0, 9'h0, 4'h0, 32'h0);

        // Reset with one response buffered and two reads still in the pipe.
        bus_a.rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0, 9'h100 + 9'(i), 4'h0, 32'h0);
        @(negedge clk);
        bus_a.req_valid_i = 1'b0;
        #1;
        chk("mid_buffered", bus_a.rsp_valid_o, 1);
        chk("mid_oce", oce_a, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus_a.rsp_valid_o, 0);
        chk("mid_rst_rdata", bus_a.rsp_rdata_o, 0);
        chk("mid_rst_ready", bus_a.req_ready_o, 1);
        chk("mid_rst_oce", oce_a, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int cc = 0; cc < 6; cc++) begin
            @(negedge clk);
            if (bus_a.rsp_valid_o) stale++;
        end
        chk("no_stale_rsp", stale, 0);
        n_acc = 0;
        for (int cc = 0; cc < 8; cc++) begin
            @(negedge clk);
            bus_a.req_valid_i = 1'b1;
            bus_a.req_we_i    = 1'b0;
            bus_a.req_addr_i  = 9'h100;
            #1 ok = bus_a.req_ready_o;
            @(posedge clk);
            if (ok) n_acc++;
        end
        chk("post_rst_credits", n_acc, 4);
        step_a(1'b0, 1'b0, 9'h0, 4'h0, 32'h0);

        // No output register: latency 1 and a randomized stream against a reference memory.
        for (int i = 0; i < 8; i++) begin
            step_b(1'b1, 1'b1, 9'(i), 4'hF, 32'h0B000000 + 32'(i));
            refm[i] = 32'h0B000000 + 32'(i);
        end
        step_b(1'b1, 1'b0, 9'h003, 4'h0, 32'h0);
        k  = 0;
        ok = 1'b0;
        while (k < 8 && !ok) begin
            @(negedge clk);
            k++;
            if (k == 1) bus_b.req_valid_i = 1'b0;
            ok = bus_b.rsp_valid_o;
        end
        chk("b_latency", k, 2);
        chk("b_rdata", bus_b.rsp_rdata_o, 32'h0B000003);

        n_ops   = 0;
        c       = 0;
        oce_bad = 0;
        while (n_ops < 100 && c < 400) begin
            @(negedge clk);
            c++;
            r_we   = 1'($urandom_range(0, 1));
            r_addr = 3'($urandom_range(0, 7));
            r_be   = 4'($urandom_range(0, 15));
            r_wd   = $urandom;
            bus_b.rsp_ready_i = ($urandom_range(0, 3) != 0);
            bus_b.req_valid_i = 1'b1;
            bus_b.req_we_i    = r_we;
            bus_b.req_addr_i  = 9'(r_addr);
            bus_b.req_be_i    = r_be;
            bus_b.req_wdata_i = r_wd;
            #1;
            if (oce_b !== 1'b1) oce_bad++;
            if (bus_b.rsp_valid_o && bus_b.rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("b_spurious_rsp", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("b_rand_rdata", bus_b.rsp_rdata_o, exp_v);
                end
            end
            if (bus_b.req_ready_o) begin
                n_ops++;
                if (r_we) refm[r_addr] = merge(refm[r_addr], r_wd, r_be);
                else      exp_q.push_back(refm[r_addr]);
            end
            @(posedge clk);
        end
        c = 0;
        while (exp_q.size() > 0 && c < 20) begin
            @(negedge clk);
            c++;
            bus_b.req_valid_i = 1'b0;
            bus_b.rsp_ready_i = 1'b1;
            #1;
            if (oce_b !== 1'b1) oce_bad++;
            if (bus_b.rsp_valid_o) begin
                exp_v = exp_q.pop_front();
                chk("b_drain_rdata", bus_b.rsp_rdata_o, exp_v);
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus_b.req_valid_i = 1'b0;
        #1;
        chk("b_ops", n_ops, 100);
        chk("b_drained", exp_q.size(), 0);
        chk("b_idle_valid", bus_b.rsp_valid_o, 0);
        chk("b_oce_const", oce_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
